// File: rtl/mmio_bridge_pkg.sv
// Shared definitions for the data-memory / MMIO bridge: FSM state encoding,
// default error read-back word, region decode value and channel-index sizing.
package mmio_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bridge_state_t;

  // Word handed back to the processor when a peripheral never answers.
  localparam logic [31:0] ERR_VALUE_DEFAULT = 32'hDEAD_BEEF;

  // Value of the region-select address bit that routes to the peripherals.
  localparam logic REGION_MMIO = 1'b1;

  // Width of the channel-index field; a single channel still gets one bit
  // so the index signals never collapse to zero width.
  function automatic int ch_idx_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Wait-cycle counter for peripheral accesses. Cleared when a request is
// launched, counts while enabled and flags the last permitted wait cycle.
module mmio_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count up while waiting, holding at the terminal value so it never wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/mmio_dmem_bridge.sv
// Data-port bridge splitting the processor address space into synchronous
// RAM and N_CH handshaked peripheral channels. Peripheral accesses stall the
// processor until the channel acks or the wait budget runs out, in which case
// an error word is returned and err_sticky is raised.
// Build option: define MMIO_WRITE_POST_EN to post MMIO writes into a
// one-entry buffer so the processor is not stalled by them.
module mmio_dmem_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MMIO_BIT = 16,
  parameter int N_CH     = 4,
  parameter int REG_W    = 4,
  parameter int TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_VALUE = DATA_W'(ERR_VALUE_DEFAULT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_stall,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_we,
  output logic [DATA_W-1:0]      ram_wdata,
  input  logic [DATA_W-1:0]      ram_rdata,
  output logic [N_CH-1:0]        per_req,
  output logic                   per_we,
  output logic [REG_W-1:0]       per_addr,
  output logic [DATA_W-1:0]      per_wdata,
  input  logic [N_CH*DATA_W-1:0] per_rdata,
  input  logic [N_CH-1:0]        per_ack,
  output logic                   err_sticky,
  input  logic                   err_clr
);

  localparam int CH_W = ch_idx_width(N_CH);

  bridge_state_t     state;
  logic              mmio;
  logic              access;
  logic              launch;
  logic              post_now;
  logic              posted_q;
  logic              ack_hit;
  logic              tc;
  logic              timeout_hit;
  logic [CH_W-1:0]   ch_sel;
  logic [CH_W-1:0]   ch_q;
  logic [REG_W-1:0]  reg_sel;
  logic [DATA_W-1:0] rdata_q;
  logic              unused_addr;

  assign mmio        = (cpu_addr[MMIO_BIT] == REGION_MMIO);
  assign access      = cpu_re | cpu_we;
  assign ch_sel      = (N_CH > 1) ? cpu_addr[REG_W +: CH_W] : '0;
  assign reg_sel     = cpu_addr[REG_W-1:0];
  assign launch      = (state == ST_IDLE) & access & mmio;
  assign ack_hit     = per_ack[ch_q];
  assign timeout_hit = (state == ST_WAIT) & tc & ~ack_hit;
  assign unused_addr = ^cpu_addr;

`ifdef MMIO_WRITE_POST_EN
  assign post_now = cpu_we;
`else
  assign post_now = 1'b0;
`endif

  assign ram_addr  = cpu_addr[ADDR_W-1:0];
  assign ram_wdata = cpu_wdata;
  assign ram_we    = cpu_we & ~mmio & ~cpu_stall;
  assign cpu_rdata = (state == ST_DONE) ? rdata_q : ram_rdata;

  mmio_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock(clock),
    .reset(reset),
    .clr  (launch),
    .en   (state == ST_WAIT),
    .tc   (tc)
  );

  // Stall while a blocking peripheral access is being launched or is in flight;
  // a posted write only holds back a further MMIO access behind it.
  always_comb begin
    cpu_stall = 1'b0;
    case (state)
      ST_IDLE: cpu_stall = access & mmio & ~post_now;
      ST_WAIT: cpu_stall = posted_q ? (access & mmio) : 1'b1;
      default: cpu_stall = 1'b0;
    endcase
  end

  // Request sequencer: latch the access, hold the one-hot request until ack or
  // timeout, then present the captured data for one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      per_req   <= '0;
      per_we    <= 1'b0;
      per_addr  <= '0;
      per_wdata <= '0;
      ch_q      <= '0;
      rdata_q   <= '0;
      posted_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            ch_q      <= ch_sel;
            per_addr  <= reg_sel;
            per_wdata <= cpu_wdata;
            per_we    <= cpu_we;
            per_req   <= N_CH'(1) << ch_sel;
            posted_q  <= post_now;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ack_hit) begin
            per_req <= '0;
            if (posted_q) begin
              state <= ST_IDLE;
            end else begin
              rdata_q <= per_rdata[ch_q*DATA_W +: DATA_W];
              state   <= ST_DONE;
            end
          end else if (tc) begin
            per_req <= '0;
            if (posted_q) begin
              state <= ST_IDLE;
            end else begin
              rdata_q <= ERR_VALUE;
              state   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          per_req <= '0;
        end
      endcase
    end
  end

  // Sticky timeout flag; a timeout in the same cycle as a clear keeps it set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_sticky <= 1'b0;
    end else if (timeout_hit) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: doc/mmio_dmem_bridge.md
Name: mmio_dmem_bridge

Overview:
- Parametrised data-memory bridge between the processor data port and a split address space: synchronous RAM, plus N_CH memory-mapped peripheral channels (sonar front-end, timers, LEDs).
- RAM accesses pass straight through.
- Peripheral accesses use a per-channel req/ack handshake, stall the processor until completion, and are protected by a timeout with a sticky error flag.

Parameters:
- ADDR_W, 12, RAM word-address width driven to RAM.
- DATA_W, 32, data width of CPU, RAM and peripheral buses.
- MMIO_BIT, 16, CPU address bit selecting the peripheral region (1 = MMIO).
- N_CH, 4, number of peripheral channels (power of two, 1..16).
- REG_W, 4, per-channel register-address width.
- TIMEOUT, 255, maximum wait cycles before a peripheral access aborts (≥2).
- ERR_VALUE, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clock  in  1  single system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_addr  in  32  word address from processor.
- cpu_wdata  in  DATA_W  store data.
- cpu_we  in  1  store strobe.
- cpu_re  in  1  load strobe.
- cpu_rdata  out  DATA_W  load data.
- cpu_stall  out  1  processor must hold addr/data/strobes while high.
- ram_addr  out  ADDR_W  equals cpu_addr[ADDR_W-1:0].
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  equals cpu_wdata.
- ram_rdata  in  DATA_W  RAM read data (1-cycle synchronous read).
- per_req  out  N_CH  one-hot request, held until ack or timeout.
- per_we  out  1  latched write flag for current request.
- per_addr  out  REG_W  latched register address.
- per_wdata  out  DATA_W  latched write data.
- per_rdata  in  N_CH*DATA_W  channel c read data at [c*DATA_W +: DATA_W].
- per_ack  in  N_CH  per-channel completion pulse.
- err_sticky  out  1  set on timeout, cleared by err_clr.
- err_clr  in  1  synchronous clear of err_sticky.

Behaviour:
- Decode:
  - mmio = cpu_addr[MMIO_BIT].
  - ch = cpu_addr[REG_W +: log2(N_CH)].
  - reg = cpu_addr[REG_W-1:0].
  - access = cpu_re | cpu_we; if both are high, treat as a write.
- RAM path (combinational):
  - ram_we = cpu_we & ~mmio & ~cpu_stall.
  - cpu_rdata = ram_rdata except in DONE.
- FSM states IDLE, WAIT, DONE; reset state is IDLE.
- IDLE:
  - On access & mmio: latch ch, reg, wdata, we; clear counter; go to WAIT.
  - cpu_stall = 1 combinationally in that same cycle.
- WAIT:
  - per_req[ch_latched] = 1; cpu_stall = 1; counter increments each cycle.
  - per_ack[ch_latched] → latch per_rdata slice; go to DONE.
  - Counter reaches TIMEOUT-1 without ack → latch ERR_VALUE, set err_sticky, go to DONE.
  - Ack and timeout in the same cycle → ack wins, no error.
  - Acks on other channels are ignored.
- DONE:
  - cpu_stall = 0; cpu_rdata = latched data for exactly this cycle; per_req = 0.
  - The MMIO access still presented this cycle is the completing one and is not reissued; return to IDLE.
- Latency: MMIO access completes k+2 cycles after issue, where k = ack delay in cycles from req assertion (k ≥ 0).
- err_sticky: set has priority over err_clr in the same cycle.
- Reset values:
  - per_req = 0, per_we = 0, per_addr = 0, per_wdata = 0.
  - err_sticky = 0, cpu_stall = 0 (absent access), counter = 0, latched data = 0.
- Reset asserted mid-WAIT: immediate return to IDLE, per_req drops asynchronously, any outstanding ack is discarded.

Optional Feature:
- MMIO_WRITE_POST_EN defined:
  - MMIO writes are posted: in IDLE a write latches into a one-entry buffer with no stall, and WAIT proceeds in the background.
  - A further MMIO access arriving while the buffer is busy stalls until the buffer drains.
  - Reads always stall.
  - A posted-write timeout sets err_sticky; there is no data to return.
- Undefined: all MMIO accesses stall as above.

Decomposition:
- Package mmio_bridge_pkg: FSM state enum, ERR_VALUE default, channel-index width function (clog2-based), region-decode constants.
- One natural sub-module, mmio_timeout_ctr: a counter with clear, enable and terminal-count output, parameterised by TIMEOUT.

Test Plan:
- RAM store then load at addr 0x005 with data 0x1234_5678 → ram_we pulses once, next-cycle cpu_rdata = 0x1234_5678, cpu_stall never asserts.
- MMIO read of ch2/reg3 (addr 0x1_0023), ack after 3 cycles with rdata 0xA5A5_0001 → per_req = 4'b0100 for 4 cycles, stall for 5 cycles, DONE cycle cpu_rdata = 0xA5A5_0001, err_sticky = 0.
- MMIO read of ch1, no ack, TIMEOUT = 8 → stall ends after 9 cycles, cpu_rdata = 32'hDEAD_BEEF, err_sticky = 1; err_clr pulse → 0.
- Ack on ch3 while waiting on ch0 → ignored, access still completes on ch0 ack only; ack and timeout in the same cycle → data returned, no error.
- Reset low during WAIT → per_req = 0 immediately, FSM in IDLE after release, next RAM access unstalled.
- With MMIO_WRITE_POST_EN: two back-to-back MMIO writes → first has no stall, second stalls until first ack, both per_wdata values observed in order.
